// File: rtl/exe_muldiv_unit_if.sv
// EXE-stage handshake between the pipeline (master) and the iterative mul/div unit (slave).
// The pipeline holds start/operands stable while stall is high; done marks the single result cycle.
interface exe_muldiv_unit_if;
    logic        start;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  dst_reg;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  result_reg;
    logic        illegal;

    modport master (
        output start, alu_ctrl, op_a, op_b, dst_reg, flush,
        input  stall, done, result, result_reg, illegal
    );

    modport slave (
        input  start, alu_ctrl, op_a, op_b, dst_reg, flush,
        output stall, done, result, result_reg, illegal
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M mul/div for the EXE stage: 1 bit/cycle shift-add multiply and restoring divide.
// Latency: done 33 cycles after acceptance (1 cycle for divide special cases); stall holds the pipeline meanwhile.
// Divider present only when MULDIV_DIV_EN is defined; otherwise DIV-class ops complete at once flagged illegal.
module exe_muldiv_unit (
    input  logic             clk,
    input  logic             rst,
    exe_muldiv_unit_if.slave mdu
);
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_op_lo;
    logic        r_neg_q;
    logic [31:0] r_mag_b;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic [4:0]  r_dst;
    logic [31:0] r_result;
    logic [4:0]  r_result_reg;
    logic        r_illegal;

    logic        w_is_muldiv;
    logic        w_is_div;
    logic        w_accept;
    logic        w_busy;
    logic        w_last;
    logic        w_signed_a;
    logic        w_signed_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_nxt;
    logic [63:0] w_mul_prod;
    logic [63:0] w_iter_nxt;
    logic [31:0] w_res_fin;

    assign w_is_muldiv = (mdu.alu_ctrl[4:3] == 2'b10);
    assign w_is_div    = w_is_muldiv & mdu.alu_ctrl[2];
    assign w_accept    = (r_state == IDLE) & mdu.start & w_is_muldiv & ~mdu.flush;
    assign w_last      = (r_cnt == 5'd31);

    assign w_signed_a = (mdu.alu_ctrl == OP_MUL) | (mdu.alu_ctrl == OP_MULH) |
                        (mdu.alu_ctrl == OP_MULHSU) | (mdu.alu_ctrl == OP_DIV) |
                        (mdu.alu_ctrl == OP_REM);
    assign w_signed_b = (mdu.alu_ctrl == OP_MUL) | (mdu.alu_ctrl == OP_MULH) |
                        (mdu.alu_ctrl == OP_DIV) | (mdu.alu_ctrl == OP_REM);
    assign w_mag_a    = (w_signed_a & mdu.op_a[31]) ? -mdu.op_a : mdu.op_a;
    assign w_mag_b    = (w_signed_b & mdu.op_b[31]) ? -mdu.op_b : mdu.op_b;

    // r_acc = {partial product, remaining multiplier}; carry out of the add shifts into bit 63
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_mag_b};
    assign w_mul_nxt  = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};
    assign w_mul_prod = r_neg_q ? -w_mul_nxt : w_mul_nxt;

`ifdef MULDIV_DIV_EN
    logic        r_neg_r;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_sub;
    logic [63:0] w_div_nxt;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic [31:0] w_special_res;

    // r_acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign w_div_shift = r_acc[63:31];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
    assign w_div_sub   = w_div_shift[31:0] - r_mag_b;
    assign w_div_nxt   = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1}
                                  : {w_div_shift[31:0], r_acc[30:0], 1'b0};
    assign w_quo       = r_neg_q ? -w_div_nxt[31:0]  : w_div_nxt[31:0];
    assign w_rem       = r_neg_r ? -w_div_nxt[63:32] : w_div_nxt[63:32];

    assign w_div_zero    = (mdu.op_b == 32'd0);
    assign w_div_ovf     = w_signed_b & (mdu.op_a == 32'h8000_0000) & (mdu.op_b == 32'hFFFF_FFFF);
    assign w_special     = w_is_div & (w_div_zero | w_div_ovf);
    assign w_special_res = mdu.alu_ctrl[1] ? (w_div_zero ? mdu.op_a : 32'd0)
                                           : (w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
    assign w_busy        = (r_state == MUL) | (r_state == DIV);
`else
    assign w_busy        = (r_state == MUL);
`endif

    always_comb begin
        w_iter_nxt = w_mul_nxt;
        w_res_fin  = (r_op_lo == 2'b00) ? w_mul_prod[31:0] : w_mul_prod[63:32];
`ifdef MULDIV_DIV_EN
        if (r_state == DIV) begin
            w_iter_nxt = w_div_nxt;
            w_res_fin  = r_op_lo[1] ? w_rem : w_quo;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef MULDIV_DIV_EN
                    if (w_is_div) w_state_nxt = w_special ? DONE : DIV;
                    else          w_state_nxt = MUL;
`else
                    w_state_nxt = w_is_div ? DONE : MUL;
`endif
                end
            end
            MUL:     if (w_last) w_state_nxt = DONE;
`ifdef MULDIV_DIV_EN
            DIV:     if (w_last) w_state_nxt = DONE;
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Flush kills whatever is in flight, including a completion due this edge
        if (mdu.flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_lo      <= 2'd0;
            r_neg_q      <= 1'b0;
            r_mag_b      <= 32'd0;
            r_acc        <= 64'd0;
            r_cnt        <= 5'd0;
            r_dst        <= 5'd0;
            r_result     <= 32'd0;
            r_result_reg <= 5'd0;
            r_illegal    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_r      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op_lo   <= mdu.alu_ctrl[1:0];
            r_dst     <= mdu.dst_reg;
            r_cnt     <= 5'd0;
            r_acc     <= {32'd0, w_mag_a};
            r_mag_b   <= w_mag_b;
            r_neg_q   <= (w_signed_a & mdu.op_a[31]) ^ (w_signed_b & mdu.op_b[31]);
            r_illegal <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_r   <= w_signed_a & mdu.op_a[31];
            if (w_special) begin
                r_result     <= w_special_res;
                r_result_reg <= mdu.dst_reg;
            end
`else
            if (w_is_div) begin
                r_result     <= 32'd0;
                r_result_reg <= mdu.dst_reg;
                r_illegal    <= 1'b1;
            end
`endif
        end else if (w_busy & ~mdu.flush) begin
            r_acc <= w_iter_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                r_result     <= w_res_fin;
                r_result_reg <= r_dst;
            end
        end
    end

    assign mdu.done       = (r_state == DONE);
    assign mdu.illegal    = (r_state == DONE) & r_illegal;
    assign mdu.stall      = mdu.start & w_is_muldiv & ~mdu.done;
    assign mdu.result     = r_result;
    assign mdu.result_reg = r_result_reg;
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Table-driven bench for exe_muldiv_unit with a done-side scoreboard plus flush/reset sequences.
// Divide rows expect real results only when MULDIV_DIV_EN is defined, otherwise an illegal completion.
module tb_exe_muldiv_unit;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dst;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[$];

    exe_muldiv_unit_if mdu_if();

    exe_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] dst, input logic [31:0] res, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.dst = dst; v.res = res; v.ill = 1'b0; v.lat = lat;
        return v;
    endfunction

    // Divide-class row: without the divider every such op completes next cycle as illegal with result 0
    function automatic vec_t mkd(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] dst, input logic [31:0] res, input int lat);
        vec_t v;
        v = mk(op, a, b, dst, DIV_EN ? res : 32'd0, DIV_EN ? lat : 1);
        v.ill = ~DIV_EN;
        return v;
    endfunction

    always @(negedge clk) begin
        if (mdu_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", mdu_if.result, mon_e.res);
                check("result_reg", {27'd0, mdu_if.result_reg}, {27'd0, mon_e.dst});
                check("illegal", {31'd0, mdu_if.illegal}, {31'd0, mon_e.ill});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends the DONE cycle.
    task automatic run_op(input vec_t v);
        int  k;
        int  st;
        bit  seen;
        exp_t e;
        mdu_if.start    = 1'b1;
        mdu_if.alu_ctrl = v.op;
        mdu_if.op_a     = v.a;
        mdu_if.op_b     = v.b;
        mdu_if.dst_reg  = v.dst;
        e.res = v.res; e.dst = v.dst; e.ill = v.ill;
        sb_q.push_back(e);
        k = 0; st = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            if (mdu_if.done === 1'b1) begin
                seen = 1'b1;
                check("stall_in_done", {31'd0, mdu_if.stall}, 32'd0);
            end else if (mdu_if.stall === 1'b1) begin
                st++;
            end
            @(posedge clk); #1;
            if (!seen) k++;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end else begin
            check("latency", k, v.lat);
            check("stall_cycles", st, v.lat);
        end
    endtask

    task automatic go_idle();
        mdu_if.start    = 1'b0;
        mdu_if.alu_ctrl = 5'd0;
        mdu_if.flush    = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mdu_if.done === 1'b1) pulses++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int   pulses;
        vec_t v;
        n_chk = 0;
        n_err = 0;

        vecs.push_back(mk (5'b10000, 32'd7,          32'd6,          5'd3,  32'd42,         33));
        vecs.push_back(mk (5'b10001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'h0000_0000,  33));
        vecs.push_back(mk (5'b10011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE,  33));
        vecs.push_back(mk (5'b10010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'hFFFF_FFFF,  33));
        vecs.push_back(mk (5'b10000, 32'hFFFF_FFFD,  32'd5,          5'd7,  32'hFFFF_FFF1,  33));
        vecs.push_back(mk (5'b10001, 32'h8000_0000,  32'h8000_0000,  5'd8,  32'h4000_0000,  33));
        vecs.push_back(mk (5'b10000, 32'h1234_5678,  32'h0000_0100,  5'd9,  32'h3456_7800,  33));
        vecs.push_back(mk (5'b10011, 32'h8000_0000,  32'd2,          5'd10, 32'h0000_0001,  33));
        vecs.push_back(mkd(5'b10100, 32'hFFFF_FFF9,  32'd2,          5'd11, 32'hFFFF_FFFD,  33));
        vecs.push_back(mkd(5'b10110, 32'hFFFF_FFF9,  32'd2,          5'd12, 32'hFFFF_FFFF,  33));
        vecs.push_back(mkd(5'b10101, 32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF,  1));
        vecs.push_back(mkd(5'b10111, 32'd5,          32'd0,          5'd14, 32'd5,          1));
        vecs.push_back(mkd(5'b10100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  1));
        vecs.push_back(mkd(5'b10110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          1));
        vecs.push_back(mkd(5'b10101, 32'd100,        32'd7,          5'd17, 32'd14,         33));
        vecs.push_back(mkd(5'b10111, 32'd100,        32'd7,          5'd18, 32'd2,          33));
        vecs.push_back(mkd(5'b10100, 32'd7,          32'hFFFF_FFFE,  5'd19, 32'hFFFF_FFFD,  33));
        vecs.push_back(mkd(5'b10110, 32'd7,          32'hFFFF_FFFE,  5'd20, 32'd1,          33));
        vecs.push_back(mkd(5'b10100, 32'h8000_0000,  32'd2,          5'd21, 32'hC000_0000,  33));
        vecs.push_back(mkd(5'b10101, 32'hFFFF_FFFF,  32'd1,          5'd22, 32'hFFFF_FFFF,  33));
        vecs.push_back(mkd(5'b10100, 32'hFFFF_FFFB,  32'd0,          5'd23, 32'hFFFF_FFFF,  1));
        vecs.push_back(mkd(5'b10110, 32'hFFFF_FFFB,  32'd0,          5'd24, 32'hFFFF_FFFB,  1));

        rst = 1'b1;
        go_idle();
        mdu_if.op_a = 32'd0; mdu_if.op_b = 32'd0; mdu_if.dst_reg = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {31'd0, mdu_if.done}, 32'd0);
        check("rst_illegal", {31'd0, mdu_if.illegal}, 32'd0);
        check("rst_result", mdu_if.result, 32'd0);
        check("rst_result_reg", {27'd0, mdu_if.result_reg}, 32'd0);
        check("rst_stall", {31'd0, mdu_if.stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Non-muldiv op held valid: no stall, and the scoreboard flags any done
        mdu_if.start = 1'b1; mdu_if.alu_ctrl = 5'b00010; mdu_if.op_a = 32'd3; mdu_if.op_b = 32'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nonmuldiv_stall", {31'd0, mdu_if.stall}, 32'd0);
        end
        @(posedge clk); #1;

        // Rows run back to back: each new op is presented right after the previous DONE edge
        foreach (vecs[i]) run_op(vecs[i]);
        go_idle();
        @(posedge clk); #1;

        // Flush in cycle 10 of a multiply
        mdu_if.start = 1'b1; mdu_if.alu_ctrl = 5'b10000;
        mdu_if.op_a = 32'd9; mdu_if.op_b = 32'd9; mdu_if.dst_reg = 5'd25;
        repeat (10) @(posedge clk);
        #1;
        mdu_if.flush = 1'b1;
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        check("flush_stall", {31'd0, mdu_if.stall}, 32'd0);
        count_done(40, pulses);
        check("flush_done_pulses", pulses, 0);
        run_op(mk(5'b10000, 32'd11, 32'd13, 5'd26, 32'd143, 33));
        go_idle();
        @(posedge clk); #1;

        // Reset asserted in cycle 5 of an iterative op
        v = DIV_EN ? mk(5'b10101, 32'd100, 32'd7, 5'd27, 32'd14, 33)
                   : mk(5'b10000, 32'd100, 32'd7, 5'd27, 32'd700, 33);
        mdu_if.start = 1'b1; mdu_if.alu_ctrl = v.op;
        mdu_if.op_a = v.a; mdu_if.op_b = v.b; mdu_if.dst_reg = v.dst;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_result", mdu_if.result, 32'd0);
        check("midrst_result_reg", {27'd0, mdu_if.result_reg}, 32'd0);
        check("midrst_done", {31'd0, mdu_if.done}, 32'd0);
        #2;
        go_idle();
        rst = 1'b0;
        count_done(40, pulses);
        check("midrst_done_pulses", pulses, 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
